spike_aer_encoder: RTL

- Sits directly downstream of eif_neuron and consumes its 1-bit spike output.
- Time-stamps each spike cycle against a free-running counter and queues the result in a small FIFO.
- Emits the queue as address-event words on a valid/ready stream toward the off-chip or readout interface.
- Inserts a wrap-marker event each time the timestamp counter rolls over, so the consumer can reconstruct absolute time.

---
 rtl/eif_aer_pkg.sv | 20 ++
 rtl/spike_evt_fifo.sv | 78 +++++++
 rtl/spike_aer_encoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/eif_aer_pkg.sv
// eif_aer_pkg
//   Shared definitions for the spike address-event path behind eif_neuron.
//   - evt_type_e : type bit carried in the MSB of every event word
//   - evt_word_w : event word width for a given timestamp width
//   - DROP_CNT_W : width of the optional lost-event counter
package eif_aer_pkg;

  typedef enum logic {
    EVT_SPIKE = 1'b0,
    EVT_WRAP  = 1'b1
  } evt_type_e;

  localparam int DROP_CNT_W = 8;

  // One type bit on top of the timestamp field.
  function automatic int evt_word_w(input int ts_w);
    return ts_w + 1;
  endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// spike_evt_fifo
//   Synchronous FIFO for AER event words with a registered head.
//   The head register is loaded at the same edge that makes an entry the
//   oldest one, so the word is visible the cycle after it is written.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (pointers, count, head)
//   push, push_data   write request and word; ignored when full unless popping
//   pop               remove the head entry; ignored when empty
//   full, empty       occupancy flags
//   level             number of stored entries (0..DEPTH)
//   head              oldest entry; keeps its last value when empty
module spike_evt_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic [WIDTH-1:0]        head
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic             push_ok;
  logic             pop_ok;
  logic [AW:0]      remaining;

  assign full       = (level == FULL_LEVEL);
  assign empty      = (level == '0);
  assign pop_ok     = pop & ~empty;
  // A full FIFO still takes a word when a pop frees a slot at the same edge.
  assign push_ok    = push & (~full | pop_ok);
  assign rd_ptr_nxt = rd_ptr + AW'(1);
  // Entries left over from before this edge once the pop is applied.
  assign remaining  = level - (AW+1)'(pop_ok);

  // Storage array, no reset needed: validity is tracked by level.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_nxt;
      end
      level <= remaining + (AW+1)'(push_ok);
      // Nothing older survives: the incoming word becomes the head directly.
      if (push_ok && (remaining == '0)) begin
        head <= push_data;
      end else if (pop_ok && (remaining != '0)) begin
        head <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder
//   Time-stamps every cycle in which eif_neuron's spike output is high,
//   queues {type, timestamp} event words and streams them out on a
//   valid/ready interface. A wrap-marker word {EVT_WRAP, 0} is queued after
//   each timestamp rollover so the reader can rebuild absolute time.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   spike                spike level; each high cycle is one event
//   out_valid/out_ready  output handshake, word taken when both are high
//   out_data             {type, timestamp}, held while waiting for out_ready
//   level                current FIFO occupancy
//   overflow             sticky flag, set when any event is lost
//   drop_cnt             saturating lost-event count (only with the option)
// Build option:
//   SPIKE_AER_DROP_CNT_EN adds drop_cnt; overflow is then drop_cnt != 0.
module spike_aer_encoder
  import eif_aer_pkg::*;
#(
  parameter int TS_W  = 8,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spike,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [evt_word_w(TS_W)-1:0]   out_data,
  output logic [$clog2(DEPTH):0]        level,
`ifdef SPIKE_AER_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]         drop_cnt,
`endif
  output logic                          overflow
);

  localparam int EW = evt_word_w(TS_W);

  logic [TS_W-1:0] ts;
  logic            wrap_req;
  logic            wrap_pend;
  logic            pop;
  logic            can_push;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic [EW-1:0]   push_data;
  logic            mark_write;
  logic            spike_drop;
  logic            mark_drop;

  assign wrap_req  = &ts;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign can_push  = ~fifo_full | pop;

  // Write arbitration: a spike always wins the single write slot; a pending
  // marker only goes in on a spike-free cycle with room in the FIFO.
  always_comb begin
    push       = 1'b0;
    push_data  = '0;
    mark_write = 1'b0;
    spike_drop = 1'b0;
    if (spike) begin
      push       = can_push;
      push_data  = {EVT_SPIKE, ts};
      spike_drop = ~can_push;
    end else if (wrap_pend && can_push) begin
      push       = 1'b1;
      push_data  = {EVT_WRAP, {TS_W{1'b0}}};
      mark_write = 1'b1;
    end
    // Only one marker can be outstanding; a second rollover before the first
    // marker is written loses the new one.
    mark_drop = wrap_req & wrap_pend & ~mark_write;
  end

  // Free-running timestamp and the outstanding wrap-marker request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts        <= '0;
      wrap_pend <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (wrap_req) begin
        wrap_pend <= 1'b1;
      end else if (mark_write) begin
        wrap_pend <= 1'b0;
      end
    end
  end

`ifdef SPIKE_AER_DROP_CNT_EN
  logic [1:0]          drop_inc;
  logic [DROP_CNT_W:0] drop_sum;

  // A spike and a marker can both be lost in the same cycle.
  assign drop_inc = {1'b0, spike_drop} + {1'b0, mark_drop};
  assign drop_sum = {1'b0, drop_cnt} + {{(DROP_CNT_W-1){1'b0}}, drop_inc};

  // Saturating lost-event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_sum[DROP_CNT_W]) begin
      drop_cnt <= '1;
    end else begin
      drop_cnt <= drop_sum[DROP_CNT_W-1:0];
    end
  end

  assign overflow = (drop_cnt != '0);
`else
  // Sticky loss flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (spike_drop || mark_drop) begin
      overflow <= 1'b1;
    end
  end
`endif

  spike_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level),
    .head      (out_data)
  );

endmodule
